// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch front end.
//   NOP_INST      : instruction word driven to decode when IF/ID is empty
//   fetch_entry_t : one prefetch-queue slot, {PC+4, instruction}
//   fetch_state_t : fetch request FSM states
//   word_align    : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Masking (rather than slicing) keeps every input bit referenced.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// -----------------------------------------------------------------------------
// prefetch_fifo
// DEPTH-entry circular buffer holding fetched {PC+4, instruction} pairs.
// Ports:
//   f_clk, rst  : clock, asynchronous active-high reset
//   flush       : empties the queue (wins over push/pop)
//   push        : write push_entry at the tail (never asserted when full)
//   push_entry  : entry to write
//   pop         : advance the head (never asserted when empty)
//   head        : entry at the head of the queue
//   count       : number of valid entries, 0..DEPTH
//   empty       : count == 0
// -----------------------------------------------------------------------------
module prefetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       f_clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge f_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are qualified by count so it needs no reset.
  always_ff @(posedge f_clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/ifetch_prefetch.sv
// -----------------------------------------------------------------------------
// ifetch_prefetch
// Instruction-fetch front end: owns the PC, issues one outstanding read at a
// time on a req/ack instruction-memory port, buffers returned words in a
// prefetch queue and drives the registered IF/ID outputs to decode.
// Ports:
//   f_clk, rst   : clock, asynchronous active-high reset
//   mem_req      : registered read request, held until mem_ack
//   mem_addr     : registered word-aligned read address
//   mem_ack      : request accepted, mem_rdata valid this cycle
//   mem_rdata    : returned instruction word
//   stall        : decode hazard; IF/ID holds, queue does not pop
//   redirect     : taken branch/jump; flush queue and IF/ID, refetch
//   redirect_pc  : new fetch target (byte offset ignored)
//   d_valid      : IF/ID holds a real instruction
//   d_inst       : IF/ID instruction (NOP_INST when not valid)
//   d_pc         : PC+4 of d_inst (0 when not valid)
// -----------------------------------------------------------------------------
module ifetch_prefetch
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        f_clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        d_valid,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

  fetch_state_t  state_r,    state_s;
  logic          mem_req_r,  mem_req_s;
  logic [31:0]   mem_addr_r, mem_addr_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic          d_valid_r,  d_valid_s;
  logic [31:0]   d_inst_r,   d_inst_s;
  logic [31:0]   d_pc_r,     d_pc_s;

  logic [31:0]   target_pc_s;
  logic [31:0]   next_pc_s;
  logic          push_s;
  logic          pop_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;
  logic [CW-1:0] count_s;
  logic          empty_s;
  logic [CW-1:0] count_after_s;

  assign target_pc_s  = word_align(redirect_pc);
  assign next_pc_s    = fetch_pc_r + 32'd4;
  assign push_entry_s = '{pc4: next_pc_s, inst: mem_rdata};

  // A redirect flushes the queue this edge, so it never pops.
  assign pop_s = !redirect && !stall && !empty_s;

  // Occupancy after this edge's push and pop: decides whether the next
  // back-to-back request can still be accepted into the queue.
  assign count_after_s = count_s + CNT_ONE - CW'(pop_s);

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .f_clk      (f_clk),
    .rst        (rst),
    .flush      (redirect),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .count      (count_s),
    .empty      (empty_s)
  );

  // Fetch FSM next-state and memory-request logic.
  always_comb begin
    state_s    = state_r;
    mem_req_s  = mem_req_r;
    mem_addr_s = mem_addr_r;
    fetch_pc_s = fetch_pc_r;
    push_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          fetch_pc_s = target_pc_s;
        end else if (count_s < DEPTH_CNT) begin
          mem_req_s  = 1'b1;
          mem_addr_s = fetch_pc_r;
          state_s    = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (redirect && mem_ack) begin
          // Stale word returned on the redirect edge: drop it and reissue
          // straight away at the new target.
          mem_req_s  = 1'b1;
          mem_addr_s = target_pc_s;
          fetch_pc_s = target_pc_s;
        end else if (redirect) begin
          // The old request must still complete; its data is thrown away.
          fetch_pc_s = target_pc_s;
          state_s    = DRAIN;
        end else if (mem_ack) begin
          push_s     = 1'b1;
          fetch_pc_s = next_pc_s;
          if (count_after_s < DEPTH_CNT) begin
            mem_addr_s = next_pc_s;
          end else begin
            mem_req_s = 1'b0;
            state_s   = IDLE;
          end
        end else begin
          state_s = REQ;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          mem_req_s = 1'b1;
          state_s   = REQ;
          if (redirect) begin
            fetch_pc_s = target_pc_s;
            mem_addr_s = target_pc_s;
          end else begin
            mem_addr_s = fetch_pc_r;
          end
        end else if (redirect) begin
          fetch_pc_s = target_pc_s;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s   = IDLE;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // IF/ID next-value selection: redirect, then stall, then queue head.
  always_comb begin
    d_valid_s = d_valid_r;
    d_inst_s  = d_inst_r;
    d_pc_s    = d_pc_r;
    if (redirect) begin
      d_valid_s = 1'b0;
      d_inst_s  = NOP_INST;
      d_pc_s    = 32'h0000_0000;
    end else if (stall) begin
      d_valid_s = d_valid_r;
    end else if (!empty_s) begin
      d_valid_s = 1'b1;
      d_inst_s  = head_s.inst;
      d_pc_s    = head_s.pc4;
    end else begin
      d_valid_s = 1'b0;
      d_inst_s  = NOP_INST;
      d_pc_s    = 32'h0000_0000;
    end
  end

  // Fetch FSM, memory port and IF/ID registers.
  always_ff @(posedge f_clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      mem_req_r  <= 1'b0;
      mem_addr_r <= RESET_PC;
      fetch_pc_r <= RESET_PC;
      d_valid_r  <= 1'b0;
      d_inst_r   <= NOP_INST;
      d_pc_r     <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      fetch_pc_r <= fetch_pc_s;
      d_valid_r  <= d_valid_s;
      d_inst_r   <= d_inst_s;
      d_pc_r     <= d_pc_s;
    end
  end

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign d_valid  = d_valid_r;
  assign d_inst   = d_inst_r;
  assign d_pc     = d_pc_r;

endmodule
